// File: rtl/axilite_pkg.sv
// rtl/axilite_pkg.sv - shared types and constants for the AXI-Lite master
//
// Purpose : write/read path state encodings and the data word returned on a
//           read that gives up waiting (only produced when the design is built
//           with AXIL_MASTER_TIMEOUT_EN).
// Ports   : none (package).
package axilite_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [31:0] AXIL_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axilite_phase_timer.sv
// rtl/axilite_phase_timer.sv - per-path handshake wait counter
//
// Purpose : counts consecutive cycles a path spends waiting for a handshake.
//           Used only when the master is built with AXIL_MASTER_TIMEOUT_EN.
// Ports   : clk, rst_n  - clock, asynchronous active-low reset
//           clear       - return the count to zero (idle or handshake seen)
//           incr        - this cycle is a waiting cycle
//           expired     - this waiting cycle is the LIMIT-th in a row
module axilite_phase_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (incr) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of earlier waiting cycles, so the current one is
  // the LIMIT-th when cnt == LIMIT-1.
  assign expired = incr && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/axilite_master.sv
// rtl/axilite_master.sv - backend request to AXI-Lite master bridge (posted writes)
//
// Purpose : turns single-beat backend read/write requests into AXI-Lite master
//           transactions. Writes issue AW then W and finish on W acceptance
//           (no B channel). Read and write paths are independent.
// Macro   : AXIL_MASTER_TIMEOUT_EN - when defined, each path abandons a phase
//           after TIMEOUT_CYC waiting cycles and reports done+err; reads then
//           return AXIL_TIMEOUT_DATA.
// Ports   : axi_aclk, axi_aresetn            - clock, async active-low reset
//           bk_wstart/waddr/wdata/wstrb      - write request
//           bk_wbusy/bk_wdone/bk_werr        - write status
//           bk_rstart/bk_raddr               - read request
//           bk_rbusy/bk_rdata/bk_rdone/bk_rerr - read status and data
//           axi_aw*, axi_w*, axi_ar*, axi_r* - AXI-Lite master channels
module axilite_master
  import axilite_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                bk_wstart,
  input  logic [ADDR_W-1:0]   bk_waddr,
  input  logic [DATA_W-1:0]   bk_wdata,
  input  logic [DATA_W/8-1:0] bk_wstrb,
  output logic                bk_wbusy,
  output logic                bk_wdone,
  output logic                bk_werr,
  input  logic                bk_rstart,
  input  logic [ADDR_W-1:0]   bk_raddr,
  output logic                bk_rbusy,
  output logic [DATA_W-1:0]   bk_rdata,
  output logic                bk_rdone,
  output logic                bk_rerr,
  output logic                axi_awvalid,
  output logic [ADDR_W-1:0]   axi_awaddr,
  input  logic                axi_awready,
  output logic                axi_wvalid,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wready,
  output logic                axi_arvalid,
  output logic [ADDR_W-1:0]   axi_araddr,
  input  logic                axi_arready,
  input  logic                axi_rvalid,
  input  logic [DATA_W-1:0]   axi_rdata,
  output logic                axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  // ---------------- write path ----------------
  wr_state_e           w_state, w_state_nx;
  logic                w_accept, aw_hs, w_hs, w_to;
  logic                w_done_nx, w_err_nx;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;

  // The done cycle still counts as busy, so a start there is not taken.
  assign w_accept = (w_state == W_IDLE) && !bk_wdone && bk_wstart;
  assign aw_hs    = (w_state == W_ADDR) && axi_awready;
  assign w_hs     = (w_state == W_DATA) && axi_wready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) w_state <= W_IDLE;
    else              w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    case (w_state)
      W_IDLE: if (w_accept) w_state_nx = W_ADDR;
      W_ADDR: begin
        if (aw_hs) begin
          w_state_nx = W_DATA;
        end else if (w_to) begin
          w_state_nx = W_IDLE;
          w_done_nx  = 1'b1;
          w_err_nx   = 1'b1;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_state_nx = W_IDLE;
          w_done_nx  = 1'b1;
        end else if (w_to) begin
          w_state_nx = W_IDLE;
          w_done_nx  = 1'b1;
          w_err_nx   = 1'b1;
        end
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bk_wdone <= 1'b0;
      bk_werr  <= 1'b0;
    end else begin
      bk_wdone <= w_done_nx;
      bk_werr  <= w_err_nx;
      if (w_accept) begin
        w_addr_q <= bk_waddr;
        w_data_q <= bk_wdata;
        w_strb_q <= bk_wstrb;
      end
    end
  end

  assign axi_awvalid = (w_state == W_ADDR);
  assign axi_awaddr  = w_addr_q;
  assign axi_wvalid  = (w_state == W_DATA);
  assign axi_wdata   = w_data_q;
  assign axi_wstrb   = w_strb_q;
  assign bk_wbusy    = (w_state != W_IDLE) || bk_wdone;

  // ---------------- read path ----------------
  rd_state_e           r_state, r_state_nx;
  logic                r_accept, ar_hs, r_hs, r_to;
  logic                r_done_nx, r_err_nx;
  logic [ADDR_W-1:0]   r_addr_q;

  assign r_accept = (r_state == R_IDLE) && !bk_rdone && bk_rstart;
  assign ar_hs    = (r_state == R_ADDR) && axi_arready;
  assign r_hs     = (r_state == R_DATA) && axi_rvalid;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= R_IDLE;
    else              r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    r_done_nx  = 1'b0;
    r_err_nx   = 1'b0;
    case (r_state)
      R_IDLE: if (r_accept) r_state_nx = R_ADDR;
      R_ADDR: begin
        if (ar_hs) begin
          r_state_nx = R_DATA;
        end else if (r_to) begin
          r_state_nx = R_IDLE;
          r_done_nx  = 1'b1;
          r_err_nx   = 1'b1;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          r_state_nx = R_IDLE;
          r_done_nx  = 1'b1;
        end else if (r_to) begin
          r_state_nx = R_IDLE;
          r_done_nx  = 1'b1;
          r_err_nx   = 1'b1;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_addr_q <= '0;
      bk_rdata <= '0;
      bk_rdone <= 1'b0;
      bk_rerr  <= 1'b0;
    end else begin
      bk_rdone <= r_done_nx;
      bk_rerr  <= r_err_nx;
      if (r_accept) r_addr_q <= bk_raddr;
      if (r_hs)          bk_rdata <= axi_rdata;
      else if (r_err_nx) bk_rdata <= DATA_W'(AXIL_TIMEOUT_DATA);
    end
  end

  assign axi_arvalid = (r_state == R_ADDR);
  assign axi_araddr  = r_addr_q;
  assign axi_rready  = (r_state == R_DATA);
  assign bk_rbusy    = (r_state != R_IDLE) || bk_rdone;

  // ---------------- optional phase timeout ----------------
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic w_wait, r_wait;

  // Waiting = in a handshake phase with no handshake this cycle; anything
  // else (idle or a handshake) restarts the count for the next phase.
  assign w_wait = ((w_state == W_ADDR) && !axi_awready) ||
                  ((w_state == W_DATA) && !axi_wready);
  assign r_wait = ((r_state == R_ADDR) && !axi_arready) ||
                  ((r_state == R_DATA) && !axi_rvalid);

  axilite_phase_timer #(.LIMIT(TIMEOUT_CYC)) u_wr_timer (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .clear   (!w_wait),
    .incr    (w_wait),
    .expired (w_to)
  );

  axilite_phase_timer #(.LIMIT(TIMEOUT_CYC)) u_rd_timer (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .clear   (!r_wait),
    .incr    (r_wait),
    .expired (r_to)
  );
`else
  // No timers: a negative limit is meaningless, so this is constant 0 and
  // both paths wait indefinitely.
  assign w_to = (TIMEOUT_CYC < 0);
  assign r_to = (TIMEOUT_CYC < 0);
`endif

endmodule
